padring_in_filter: RTL and testbench



---
 rtl/padring_in_filter_pkg.sv | 10 +
 rtl/padring_in_filter_if.sv | 15 +
 rtl/padring_in_filter_chan.sv | 45 ++++
 rtl/padring_in_filter.sv | 40 ++++
 tb/tb_padring_in_filter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/padring_in_filter_pkg.sv
// padring_in_filter_pkg: shared pad-ring constants for the receive-side input filter.
package padring_in_filter_pkg;
    localparam int NMioPads         = 16;
    localparam int NDioPads         = 4;
    localparam int AttrDw           = 8;
    localparam int PadAttrInvBit    = 0;
    localparam int PadAttrFiltEnBit = 4;
    localparam int FiltCntW         = 4;
    localparam int SyncStages       = 2;
endpackage

// File: rtl/padring_in_filter_if.sv
// padring_in_filter_if: pad-side inputs, attributes and filtered level/edge outputs of one bank.
interface padring_in_filter_if #(
    parameter int NPads    = 16,
    parameter int AttrDw   = 8,
    parameter int FiltCntW = 4
);
    logic [NPads-1:0]        pad_in_i;
    logic [NPads*AttrDw-1:0] attr_i;
    logic [FiltCntW-1:0]     filt_thresh_i;
    logic [NPads-1:0]        in_o;
    logic [NPads-1:0]        rise_o;
    logic [NPads-1:0]        fall_o;
    modport master (output pad_in_i, attr_i, filt_thresh_i, input in_o, rise_o, fall_o);
    modport slave  (input pad_in_i, attr_i, filt_thresh_i, output in_o, rise_o, fall_o);
endinterface

// File: rtl/padring_in_filter_chan.sv
// padring_in_filter_chan: one pad's synchroniser, invert, glitch filter, stable level and edge pulses.
module padring_in_filter_chan #(
    parameter int FiltCntW   = 4,
    parameter int SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pad,
    input  logic                inv,
    input  logic                fen,
    input  logic [FiltCntW-1:0] thresh,
    input  logic                primed,
    output logic                st,
    output logic                rise,
    output logic                fall
);
    logic [SyncStages-1:0] sync_q;
    logic [FiltCntW-1:0]   cnt_q, cnt_d;
    logic [FiltCntW:0]     cnt_inc, t_eff;
    logic                  s, hit, st_d;
    // Threshold 0 behaves as 1; the counter clears on the update edge so it never exceeds T.
    always_comb begin
        s       = sync_q[SyncStages-1] ^ inv;
        t_eff   = (thresh == '0) ? (FiltCntW+1)'(1) : {1'b0, thresh};
        cnt_inc = {1'b0, cnt_q} + 1'b1;
        hit     = fen && (s != st) && (cnt_inc >= t_eff);
        st_d    = (!fen || hit) ? s : st;
        cnt_d   = (!fen || s == st || hit) ? '0 : cnt_inc[FiltCntW-1:0];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            st     <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pad};
            cnt_q  <= cnt_d;
            st     <= st_d;
            rise   <= primed & st_d & ~st;
            fall   <= primed & ~st_d & st;
        end
    end
endmodule

// File: rtl/padring_in_filter.sv
// padring_in_filter: per-bank pad input resynchroniser and glitch filter with rise/fall pulses.
module padring_in_filter #(
    parameter int NPads      = padring_in_filter_pkg::NMioPads,
    parameter int AttrDw     = padring_in_filter_pkg::AttrDw,
    parameter int FiltCntW   = padring_in_filter_pkg::FiltCntW,
    parameter int SyncStages = padring_in_filter_pkg::SyncStages
) (
    input logic                  clk_i,
    input logic                  rst_i,
    padring_in_filter_if.slave   bus
);
    import padring_in_filter_pkg::*;
    localparam int PW = $clog2(SyncStages + 2);
    localparam logic [PW-1:0] PrimeMax = PW'(SyncStages + 1);
    logic [PW-1:0] prime_q;
    logic          primed;
    // Edge pulses stay masked until the synchronisers have flushed their post-reset contents.
    assign primed = prime_q == PrimeMax;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prime_q <= '0;
        else       prime_q <= primed ? prime_q : prime_q + 1'b1;
    end
    for (genvar k = 0; k < NPads; k++) begin : g_chan
        padring_in_filter_chan #(
            .FiltCntW  (FiltCntW),
            .SyncStages(SyncStages)
        ) u_chan (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .pad   (bus.pad_in_i[k]),
            .inv   (bus.attr_i[k*AttrDw + PadAttrInvBit]),
            .fen   (bus.attr_i[k*AttrDw + PadAttrFiltEnBit]),
            .thresh(bus.filt_thresh_i),
            .primed(primed),
            .st    (bus.in_o[k]),
            .rise  (bus.rise_o[k]),
            .fall  (bus.fall_o[k])
        );
    end
endmodule

// File: tb/tb_padring_in_filter.sv
// tb_padring_in_filter: directed stimulus checked every cycle against a run-length filter model.
module tb_padring_in_filter;
    localparam int NP = 16, AW = 8, CW = 4, SS = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0, checks = 0;
    padring_in_filter_if #(.NPads(NP), .AttrDw(AW), .FiltCntW(CW)) bus ();
    padring_in_filter #(.NPads(NP), .AttrDw(AW), .FiltCntW(CW), .SyncStages(SS)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );
    always #5 clk = ~clk;

    logic [SS-1:0] hist [NP];
    int            run  [NP];
    logic [NP-1:0] m_in, m_rise, m_fall;
    int            since_reset;
    logic [NP-1:0] acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_in = '0; m_rise = '0; m_fall = '0; since_reset = 0;
        for (int k = 0; k < NP; k++) begin
            hist[k] = '0;
            run[k]  = 0;
        end
    endtask

    // Level follows s once s has disagreed with it for T consecutive samples (T=0 -> 1).
    task automatic tick();
        logic [NP-1:0] nxt;
        logic s;
        int t;
        @(posedge clk);
        if (rst) model_clear();
        else begin
            t = (bus.filt_thresh_i == 0) ? 1 : int'(bus.filt_thresh_i);
            nxt = m_in;
            for (int k = 0; k < NP; k++) begin
                s = hist[k][SS-1] ^ bus.attr_i[k*AW];
                if (!bus.attr_i[k*AW+4]) begin
                    nxt[k] = s;
                    run[k] = 0;
                end else if (s == m_in[k]) run[k] = 0;
                else begin
                    run[k]++;
                    if (run[k] >= t) begin
                        nxt[k] = s;
                        run[k] = 0;
                    end
                end
                hist[k] = {hist[k][SS-2:0], bus.pad_in_i[k]};
            end
            m_rise = (since_reset > SS) ? (nxt & ~m_in) : '0;
            m_fall = (since_reset > SS) ? (~nxt & m_in) : '0;
            m_in = nxt;
            since_reset++;
        end
        #1;
        chk("in_o", 32'(bus.in_o), 32'(m_in));
        chk("rise_o", 32'(bus.rise_o), 32'(m_rise));
        chk("fall_o", 32'(bus.fall_o), 32'(m_fall));
        acc |= bus.rise_o | bus.fall_o;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_attr(input int k, input logic inv, input logic fen);
        bus.attr_i[k*AW]   = inv;
        bus.attr_i[k*AW+4] = fen;
    endtask

    initial begin
        bus.pad_in_i = '0;
        bus.attr_i = '0;
        bus.filt_thresh_i = '0;
        model_clear();
        acc = '0;
        ticks(3);
        chk("reset_in", 32'(bus.in_o), 32'h0);
        rst = 1'b0;
        acc = '0;
        ticks(20);
        chk("idle_no_pulse", 32'(acc), 32'h0);
        chk("idle_in", 32'(bus.in_o), 32'h0);
        rst = 1'b1;
        #1;
        model_clear();
        ticks(2);
        set_attr(3, 1'b1, 1'b0);
        rst = 1'b0;
        acc = '0;
        tick();
        chk("inv3_in_t1", 32'(bus.in_o[3]), 32'h1);
        ticks(2);
        chk("inv3_in_t3", 32'(bus.in_o[3]), 32'h1);
        chk("inv3_no_rise", 32'(acc[3]), 32'h0);
        ticks(5);
        bus.pad_in_i[5] = 1'b1;
        ticks(2);
        chk("p5_in_t2", 32'(bus.in_o[5]), 32'h0);
        tick();
        chk("p5_in_t3", 32'(bus.in_o[5]), 32'h1);
        chk("p5_rise_t3", 32'(bus.rise_o[5]), 32'h1);
        tick();
        chk("p5_rise_t4", 32'(bus.rise_o[5]), 32'h0);
        bus.filt_thresh_i = 4'd4;
        set_attr(7, 1'b0, 1'b1);
        ticks(2);
        acc = '0;
        bus.pad_in_i[7] = 1'b1;
        ticks(3);
        bus.pad_in_i[7] = 1'b0;
        ticks(10);
        chk("p7_glitch_in", 32'(bus.in_o[7]), 32'h0);
        chk("p7_glitch_pulse", 32'(acc[7]), 32'h0);
        bus.pad_in_i[7] = 1'b1;
        ticks(4);
        bus.pad_in_i[7] = 1'b0;
        tick();
        chk("p7_in_t5", 32'(bus.in_o[7]), 32'h0);
        tick();
        chk("p7_in_t6", 32'(bus.in_o[7]), 32'h1);
        chk("p7_rise_t6", 32'(bus.rise_o[7]), 32'h1);
        ticks(3);
        chk("p7_in_hold", 32'(bus.in_o[7]), 32'h1);
        tick();
        chk("p7_in_fell", 32'(bus.in_o[7]), 32'h0);
        chk("p7_fall", 32'(bus.fall_o[7]), 32'h1);
        bus.filt_thresh_i = 4'd8;
        set_attr(2, 1'b0, 1'b1);
        ticks(2);
        bus.pad_in_i[2] = 1'b1;
        ticks(7);
        chk("p2_in_counting", 32'(bus.in_o[2]), 32'h0);
        set_attr(2, 1'b0, 1'b0);
        tick();
        chk("p2_in_fen_off", 32'(bus.in_o[2]), 32'h1);
        chk("p2_rise_fen_off", 32'(bus.rise_o[2]), 32'h1);
        ticks(2);
        set_attr(0, 1'b1, 1'b0);
        tick();
        chk("p0_inv_in", 32'(bus.in_o[0]), 32'h1);
        chk("p0_inv_rise", 32'(bus.rise_o[0]), 32'h1);
        bus.filt_thresh_i = 4'd6;
        set_attr(9, 1'b0, 1'b1);
        ticks(2);
        bus.pad_in_i[9] = 1'b1;
        ticks(5);
        rst = 1'b1;
        #1;
        model_clear();
        chk("arst_in", 32'(bus.in_o), 32'h0);
        chk("arst_rise", 32'(bus.rise_o), 32'h0);
        chk("arst_fall", 32'(bus.fall_o), 32'h0);
        ticks(2);
        rst = 1'b0;
        acc = '0;
        ticks(3);
        chk("prime_no_pulse", 32'(acc), 32'h0);
        chk("prime_settled", 32'(bus.in_o[2] & bus.in_o[0]), 32'h1);
        ticks(20);
        chk("p9_after_reset", 32'(bus.in_o[9]), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
